control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 29 ++
 rtl/control_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// control_unit_if -- program-memory instruction fetch bus.
//
// Signals:
//   mem_req   : instruction-byte read request (driven by the control unit)
//   mem_valid : memory byte available on mem_data this cycle
//   mem_data  : instruction byte from program memory
//
// Modports:
//   master : control unit side (issues mem_req, consumes data)
//   slave  : program memory side
interface control_unit_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  mem_req;
  logic                  mem_valid;
  logic [WORD_WIDTH-1:0] mem_data;

  modport master (
    output mem_req,
    input  mem_valid,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    output mem_valid,
    output mem_data
  );
endinterface

// File: rtl/control_unit.sv
// control_unit -- instruction sequencer for a small accumulator CPU.
//
// Fetches an opcode byte (and, for LDI/JMP/JZ, an operand byte) from
// program memory, then issues one-cycle strobes to the PC, ALU and
// accumulator. Opcode class is opcode[7:4]:
//   0x0 NOP, 0x1 ALU, 0x2 LDI, 0x3 JMP, 0x4 JZ, 0xF HLT, others illegal (NOP).
// A one-byte instruction walks FETCH_OP, DECODE, EXECUTE; a two-byte one
// adds FETCH_ARG between DECODE and EXECUTE. Each mem_valid=0 cycle in a
// fetch state holds that state for one more cycle.
//
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-low reset
//   run           : leave IDLE and start fetching
//   mem           : fetch bus (mem_req / mem_valid / mem_data)
//   pc_enable     : advance or load the PC; jump / jz qualify a load
//   jump_address  : branch target (operand register)
//   alu_op        : opcode[2:0] of the current instruction
//   alu_start     : ALU execute strobe
//   imm_write     : write imm_data to the accumulator
//   imm_data      : immediate value (operand register)
//   halted        : high while in HALT
//   illegal       : sticky undefined-opcode flag
//
// All outputs are registers, so each one reflects the current state and
// is cleared the moment reset goes low.
module control_unit #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  control_unit_if.master        mem,
  output logic                  pc_enable,
  output logic                  jump,
  output logic                  jz,
  output logic [WORD_WIDTH-1:0] jump_address,
  output logic [2:0]            alu_op,
  output logic                  alu_start,
  output logic                  imm_write,
  output logic [WORD_WIDTH-1:0] imm_data,
  output logic                  halted,
  output logic                  illegal
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH_OP  = 3'd1,
    ST_DECODE    = 3'd2,
    ST_FETCH_ARG = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] CLS_NOP = 4'h0;
  localparam logic [3:0] CLS_ALU = 4'h1;
  localparam logic [3:0] CLS_LDI = 4'h2;
  localparam logic [3:0] CLS_JMP = 4'h3;
  localparam logic [3:0] CLS_JZ  = 4'h4;
  localparam logic [3:0] CLS_HLT = 4'hF;

  state_t                state_r;
  logic [7:0]            opcode_r;
  logic [WORD_WIDTH-1:0] operand_r;
  logic                  mem_req_r;
  logic                  pc_enable_r;
  logic                  jump_r;
  logic                  jz_r;
  logic                  alu_start_r;
  logic                  imm_write_r;
  logic                  halted_r;
  logic                  illegal_r;
  logic [3:0]            cls_s;
  logic                  unused_bits_s;

  function automatic logic is_two_byte(input logic [3:0] cls);
    return (cls == CLS_LDI) || (cls == CLS_JMP) || (cls == CLS_JZ);
  endfunction

  function automatic logic is_legal(input logic [3:0] cls);
    case (cls)
      CLS_NOP, CLS_ALU, CLS_LDI, CLS_JMP, CLS_JZ, CLS_HLT: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

  assign cls_s = opcode_r[7:4];
  // opcode bit 3 carries no meaning for any defined instruction.
  assign unused_bits_s = opcode_r[3];

  // Sequencer: state, instruction registers and registered strobes.
  // Strobes default low every edge and are raised only on the edge that
  // enters the state in which they must be seen, giving one-cycle pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      opcode_r    <= 8'h00;
      operand_r   <= '0;
      mem_req_r   <= 1'b0;
      pc_enable_r <= 1'b0;
      jump_r      <= 1'b0;
      jz_r        <= 1'b0;
      alu_start_r <= 1'b0;
      imm_write_r <= 1'b0;
      halted_r    <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      mem_req_r   <= 1'b0;
      pc_enable_r <= 1'b0;
      jump_r      <= 1'b0;
      jz_r        <= 1'b0;
      alu_start_r <= 1'b0;
      imm_write_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (run) begin
            state_r   <= ST_FETCH_OP;
            mem_req_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH_OP: begin
          if (mem.mem_valid) begin
            opcode_r    <= mem.mem_data[7:0];
            state_r     <= ST_DECODE;
            // DECODE of a two-byte instruction steps the PC past the opcode.
            pc_enable_r <= is_two_byte(mem.mem_data[7:4]);
          end else begin
            mem_req_r <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (!is_legal(cls_s)) begin
            illegal_r <= 1'b1;
          end else begin
            illegal_r <= illegal_r;
          end
          if (is_two_byte(cls_s)) begin
            state_r   <= ST_FETCH_ARG;
            mem_req_r <= 1'b1;
          end else if (cls_s == CLS_HLT) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else begin
            // ALU, NOP and illegal opcodes only advance the PC.
            state_r     <= ST_EXECUTE;
            pc_enable_r <= 1'b1;
            alu_start_r <= (cls_s == CLS_ALU);
          end
        end
        ST_FETCH_ARG: begin
          if (mem.mem_valid) begin
            operand_r   <= mem.mem_data;
            state_r     <= ST_EXECUTE;
            pc_enable_r <= 1'b1;
            jump_r      <= (cls_s == CLS_JMP);
            jz_r        <= (cls_s == CLS_JZ);
            imm_write_r <= (cls_s == CLS_LDI);
          end else begin
            mem_req_r <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          state_r   <= ST_FETCH_OP;
          mem_req_r <= 1'b1;
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r  <= ST_IDLE;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = mem_req_r;
  assign pc_enable     = pc_enable_r;
  assign jump          = jump_r;
  assign jz            = jz_r;
  assign jump_address  = operand_r;
  assign imm_data      = operand_r;
  assign alu_op        = opcode_r[2:0];
  assign alu_start     = alu_start_r;
  assign imm_write     = imm_write_r;
  assign halted        = halted_r;
  assign illegal       = illegal_r;

endmodule
